// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_det_match.sv
// History shift register, fill counter and length-masked pattern compare.
// hit_o is combinational: it reports a match for the bit being shifted in
// on this cycle, so the parent can register it as the z pulse.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               x_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] mask;

  // Only the low len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (LEN_W'(i) < len_i) mask[i] = 1'b1;
  end

  // Post-shift view of history and fill; fill saturates at len.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (shift_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], x_i};
      fill_d = (fill_q < len_i) ? fill_q + LEN_W'(1) : len_i;
    end
  end

  assign hit_o = shift_i && (fill_d == len_i) &&
                 (((hist_d ^ pattern_i) & mask) == '0);

  // History and fill registers, cleared when a new run is armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial sequence detector controller: configuration registers, IDLE/RUN
// FSM, saturating match counter and sticky config error flag.
// Build option SEQ_DET_ONESHOT_EN: leave RUN on the first match.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           x_valid,
  input  logic                           x,
  output logic                           z,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           busy,
  output logic                           err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

`ifdef SEQ_DET_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               loaded_q;
  logic               err_q;
  logic               z_q;
  logic [CNT_W-1:0]   cnt_q;

  logic cfg_ok, start_acc, shift, hit;

  assign cfg_ok    = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  assign start_acc = (state_q == IDLE) && start && loaded_q;
  assign shift     = (state_q == RUN) && x_valid;

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_acc),
    .shift_i   (shift),
    .x_i       (x),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .hit_o     (hit)
  );

  // FSM with configuration load, match pulse and counter updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      z_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          z_q <= 1'b0;
          if (cfg_valid) begin
            if (cfg_ok) begin
              pat_q    <= cfg_pattern;
              len_q    <= cfg_len;
              loaded_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          // Arming uses the configuration already held, not one offered now.
          if (start_acc) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          z_q <= hit;
          if (hit && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
          // A match on the stop edge still pulses and counts above.
          if (stop || (ONESHOT && hit)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a bit-queue reference model checked every cycle,
// plus directed scenarios with literal expectations. A second instance with
// a 2-bit counter shares all inputs to exercise counter saturation.
module tb_seq_det_ctrl;

  localparam int ML = 8;
  localparam int LW = $clog2(ML + 1);

`ifdef SEQ_DET_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic          x_valid = 1'b0, x = 1'b0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;

  logic       cfg_ready, z, busy, err;
  logic [7:0] match_cnt;
  logic       cfg_ready2, z2, busy2, err2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;
  int zc = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAX_LEN(ML), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .start(start), .stop(stop),
    .x_valid(x_valid), .x(x), .z(z), .match_cnt(match_cnt), .busy(busy), .err(err)
  );

  seq_det_ctrl #(.MAX_LEN(ML), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .start(start), .stop(stop),
    .x_valid(x_valid), .x(x), .z(z2), .match_cnt(match_cnt2), .busy(busy2), .err(err2)
  );

  // ---------------- reference model ----------------
  bit          m_run, m_loaded, m_err, m_z;
  logic [ML-1:0] m_pat;
  int          m_len, m_cnt8, m_cnt2;
  bit          hq[$];

  function automatic bit tail_matches();
    if (hq.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (hq[hq.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_loaded = 0; m_err = 0; m_z = 0;
      m_pat = '0; m_len = 0; m_cnt8 = 0; m_cnt2 = 0;
      hq.delete();
    end else begin
      bit hit, was_loaded;
      hit = 0;
      was_loaded = m_loaded;
      if (!m_run) begin
        m_z = 0;
        if (cfg_valid) begin
          if (int'(cfg_len) >= 2 && int'(cfg_len) <= ML) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_loaded = 1;
          end else m_err = 1;
        end
        if (start && was_loaded) begin
          m_run = 1; hq.delete(); m_cnt8 = 0; m_cnt2 = 0;
        end
      end else begin
        if (x_valid) begin
          hq.push_back(x);
          if (hq.size() > ML) void'(hq.pop_front());
          hit = tail_matches();
        end
        m_z = hit;
        if (hit) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        if (stop || (ONESHOT && hit)) m_run = 0;
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    cmp("z", int'(z), int'(m_z));
    cmp("busy", int'(busy), int'(m_run));
    cmp("cfg_ready", int'(cfg_ready), int'(!m_run));
    cmp("err", int'(err), int'(m_err));
    cmp("match_cnt", int'(match_cnt), m_cnt8);
    cmp("match_cnt_sat", int'(match_cnt2), m_cnt2);
    cmp("z_sat", int'(z2), int'(m_z));
  end

  always @(negedge clk) if (z) zc++;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [ML-1:0] p, input int l);
    cfg_pattern = p; cfg_len = LW'(l); cfg_valid = 1; tick(); cfg_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic send(input bit b, input bit v);
    x = b; x_valid = v; tick(); x_valid = 0;
  endtask

  task automatic send_str(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) send(s[i], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    // reset state
    rst = 1; tick(); tick();
    cmp("rst_ready", int'(cfg_ready), 1);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_err", int'(err), 0);
    cmp("rst_cnt", int'(match_cnt), 0);
    cmp("rst_z", int'(z), 0);
    rst = 0;

    // overlapping detection: 1101 in 1101101
    load(8'b1101, 4);
    pulse_start();
    cmp("armed", int'(busy), 1);
    zc = 0;
    send_str(32'b1101101, 7);
    tick();
    cmp("ovl_zcount", zc, ONESHOT ? 1 : 2);
    cmp("ovl_cnt", int'(match_cnt), ONESHOT ? 1 : 2);
    cmp("ovl_busy", int'(busy), ONESHOT ? 0 : 1);
    pulse_stop();

    // rejected configurations, start without a loaded config
    do_reset();
    load(8'b1, 1);
    cmp("err_len1", int'(err), 1);
    load(8'hFF, ML + 1);
    cmp("err_lenmax", int'(err), 1);
    pulse_start();
    cmp("start_unloaded", int'(busy), 0);
    load(8'b1101, 4);
    pulse_start();
    cmp("start_loaded", int'(busy), 1);
    cmp("err_sticky", int'(err), 1);
    pulse_stop();

    // gap cycle inside the pattern
    pulse_start();
    zc = 0;
    send(1, 1); send(1, 1); send(1, 0); send(0, 1); send(1, 1);
    cmp("gap_z", int'(z), 1);
    tick();
    cmp("gap_zcount", zc, 1);
    cmp("gap_z_low", int'(z), 0);
    pulse_stop();

    // stop on the completing bit
    pulse_start();
    send(1, 1); send(1, 1); send(0, 1);
    x = 1; x_valid = 1; stop = 1; tick(); x_valid = 0; stop = 0;
    cmp("stop_z", int'(z), 1);
    cmp("stop_busy", int'(busy), 0);
    cmp("stop_cnt", int'(match_cnt), 1);

    // five matches: 2-bit counter saturates
    pulse_start();
    send_str(32'b1101101101101101, 16);
    tick();
    cmp("sat_cnt2", int'(match_cnt2), ONESHOT ? 1 : 3);
    cmp("sat_cnt8", int'(match_cnt), ONESHOT ? 1 : 5);
    pulse_stop();

    // asynchronous reset mid-stream
    pulse_start();
    send_str(32'b1101, 4);
    send(1, 1); send(1, 1);
    #3 rst = 1;
    #1;
    cmp("arst_busy", int'(busy), 0);
    cmp("arst_z", int'(z), 0);
    cmp("arst_cnt", int'(match_cnt), 0);
    cmp("arst_err", int'(err), 0);
    cmp("arst_ready", int'(cfg_ready), 1);
    tick(); rst = 0;
    pulse_start();
    cmp("arst_unloaded", int'(busy), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cfg_valid   = ($urandom_range(0, 9) == 0);
      cfg_len     = LW'($urandom_range(0, 10) < 9 ? $urandom_range(2, 4) : $urandom_range(0, 15));
      cfg_pattern = ML'($urandom);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      x_valid     = ($urandom_range(0, 3) != 0);
      x           = $urandom_range(0, 1) == 1;
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    cfg_valid = 0; start = 0; stop = 0; x_valid = 0; rst = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 MAX_LEN, default 8, maximum pattern length in bits (legal 2..16).
REQ-002 CNT_W, default 8, match counter width.
REQ-003 LEN_W, derived as clog2(MAX_LEN+1), cfg_len width; not user-overridden.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-008 cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first-received bit, bit 0 is the last.
REQ-009 cfg_len  input  LEN_W  pattern length.
REQ-010 start  input  1  single-cycle arm request.
REQ-011 stop  input  1  single-cycle disarm request.
REQ-012 x_valid  input  1  serial bit qualifier.
REQ-013 x  input  1  serial data bit.
REQ-014 z  output  1  registered match pulse.
REQ-015 match_cnt  output  CNT_W  matches since the last accepted start.
REQ-016 busy  output  1  high while in RUN.
REQ-017 err  output  1  sticky flag for a rejected configuration.

Function
REQ-018 The FSM SHALL have two states, IDLE and RUN; cfg_ready = (state==IDLE) and busy = (state==RUN).
REQ-019 In IDLE, a cfg_valid&&cfg_ready cycle SHALL load pattern and length and set the internal loaded flag if 2<=cfg_len<=MAX_LEN; otherwise it SHALL set err and keep the prior configuration.
REQ-020 In IDLE, start with loaded=1 SHALL enter RUN on the next edge and clear history, fill count and match_cnt; start with loaded=0 SHALL be ignored.
REQ-021 In RUN, each x_valid cycle SHALL shift x into the history LSB and increment the fill count, saturating at len; x_valid=0 cycles SHALL change nothing.
REQ-022 A match occurs when the post-shift fill count equals len and the low len bits of the post-shift history equal the low len bits of the pattern.
REQ-023 On a match, z SHALL be high for exactly the one cycle following the sampling edge, and match_cnt SHALL increment on that edge, saturating at all-ones.
REQ-024 Detection SHALL overlap: history is not cleared on a match, so stream 1101101 with pattern 1101 yields two matches.
REQ-025 In RUN, stop SHALL return the FSM to IDLE on the next edge; a match sampled on that same edge SHALL still pulse z and count.
REQ-026 start in RUN, and cfg_valid in RUN, SHALL be ignored; start and stop together in IDLE SHALL act as start.
REQ-027 match_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-028 rst SHALL force state=IDLE, z=0, match_cnt=0, err=0, loaded=0, history=0, fill=0, pattern=0 and len=0, so cfg_ready=1 and busy=0.
REQ-029 rst during RUN SHALL abort immediately; no z pulse is produced for a partially received pattern.

Configuration
REQ-030 With SEQ_DET_ONESHOT_EN defined, the first match SHALL move RUN->IDLE on the same edge that raises z, so match_cnt never exceeds 1 per start.
REQ-031 Without SEQ_DET_ONESHOT_EN, RUN SHALL continue until stop or rst.

Structure
REQ-032 Package seq_det_pkg SHALL hold the state typedef (IDLE, RUN) and the MAX_LEN/CNT_W default constants.
REQ-033 Sub-module seq_det_match SHALL contain the history shift register, fill counter and masked compare; seq_det_ctrl SHALL contain the FSM, configuration registers, counter and err.

Verification
REQ-034 Load 1101 with len=4, start, then drive 1101101 with x_valid=1 -> z pulses after bits 4 and 7, match_cnt=2.
REQ-035 cfg_len=1, then cfg_len=MAX_LEN+1 -> err=1 and a following start is ignored (busy stays 0); a valid config then start -> busy=1.
REQ-036 Pattern 1101 driven as 1,1,(gap x_valid=0 with x=1),0,1 -> exactly one z, in the cycle after the final valid bit.
REQ-037 stop asserted in the same cycle as the completing bit -> z=1, match_cnt increments, busy=0 one cycle later.
REQ-038 CNT_W=2 with 5 matches -> match_cnt saturates at 3; rst mid-stream -> all outputs return to reset values.
REQ-039 SEQ_DET_ONESHOT_EN build, pattern 1101, stream 1101101 -> single z, busy=0 on the z cycle, match_cnt=1.
